// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: widths, ALU opcodes,
// the pipeline-register layout and the bubble control word.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALUC_W = 4;

    localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALUC_W-1:0] ALU_SLL = 4'b1111;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '{
        valid:      1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0
    };

    typedef struct packed {
        ex_ctrl_t            ctrl;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    dest;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
        logic [REG_W-1:0]    shamt;
        logic [ALUC_W-1:0]   alu_control;
        logic                alu_src;
    } id_ex_reg_t;

    // Register 0 is hard-wired, so it never produces a hazard or a forward.
    function automatic logic reg_match(
        input logic             writes,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src
    );
        return writes && (dest != '0) && (dest == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand select for one source register: EX/MEM result, then MEM/WB result,
// then the registered read data. With en low the registered data always wins.
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic              en,
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = reg_data;
        if (en) begin
            // The younger producer (EX/MEM) holds the newer value.
            if (reg_match(exmem_reg_write, exmem_dest, src)) begin
                data = exmem_result;
            end else if (reg_match(memwb_reg_write, memwb_dest, src)) begin
                data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and operand forwarding.
// Define FORWARDING_EN for the forwarding build; otherwise every RAW hazard stalls.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_shamt,
    input  logic [ALUC_W-1:0] id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall,
    output logic [DATA_W-1:0] ALU_reg_1,
    output logic [DATA_W-1:0] ALU_reg_2,
    output logic [ALUC_W-1:0] ALU_control,
    output logic [REG_W-1:0]  shamt,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_dest,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg
);

`ifdef FORWARDING_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    id_ex_reg_t        ex_q;
    id_ex_reg_t        ex_d;
    logic              rs_hit;
    logic              rt_hit;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Hold protocol: stall=1 asks PC and IF/ID to keep their contents; the
    // decode instruction is re-presented next cycle and this stage takes a bubble.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
`ifdef FORWARDING_EN
        // Only a load in EX cannot be covered by forwarding.
        if (ex_q.ctrl.valid && ex_q.ctrl.mem_read) begin
            rs_hit = reg_match(1'b1, ex_q.dest, id_rs);
            rt_hit = reg_match(1'b1, ex_q.dest, id_rt);
        end
`else
        rs_hit = reg_match(ex_q.ctrl.valid && ex_q.ctrl.reg_write, ex_q.dest, id_rs)
              || reg_match(exmem_reg_write, exmem_dest, id_rs);
        rt_hit = reg_match(ex_q.ctrl.valid && ex_q.ctrl.reg_write, ex_q.dest, id_rt)
              || reg_match(exmem_reg_write, exmem_dest, id_rt);
`endif
        stall = rst_n && id_valid && !flush && (rs_hit || rt_hit);
    end

    // Anything that is not a live, unstalled, unflushed instruction becomes a
    // zeroed bubble so stale fields never reach the ALU or memory.
    always_comb begin
        ex_d      = '0;
        ex_d.ctrl = BUBBLE_CTRL;
        if (id_valid && !flush && !stall) begin
            ex_d.ctrl.valid      = 1'b1;
            ex_d.ctrl.mem_read   = id_mem_read;
            ex_d.ctrl.mem_write  = id_mem_write;
            ex_d.ctrl.reg_write  = id_reg_write;
            ex_d.ctrl.mem_to_reg = id_mem_to_reg;
            ex_d.rs              = id_rs;
            ex_d.rt              = id_rt;
            ex_d.dest            = id_reg_dst ? id_rd : id_rt;
            ex_d.rs_data         = id_rs_data;
            ex_d.rt_data         = id_rt_data;
            ex_d.imm             = id_imm;
            ex_d.shamt           = id_shamt;
            ex_d.alu_control     = id_alu_control;
            ex_d.alu_src         = id_alu_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ex_q.ctrl <= BUBBLE_CTRL;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit u_fwd_rs (
        .en              (FWD_ON),
        .src             (ex_q.rs),
        .reg_data        (ex_q.rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .data            (fwd_rs)
    );

    forward_unit u_fwd_rt (
        .en              (FWD_ON),
        .src             (ex_q.rt),
        .reg_data        (ex_q.rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .data            (fwd_rt)
    );

    // Stores always take the forwarded rt, even when the ALU uses the immediate.
    assign ALU_reg_1     = fwd_rs;
    assign ALU_reg_2     = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ALU_control   = ex_q.alu_control;
    assign shamt         = ex_q.shamt;
    assign ex_valid      = ex_q.ctrl.valid;
    assign ex_dest       = ex_q.dest;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/forwarding steps, then random traffic
// against a reference model of the stage contents. Works with or without FORWARDING_EN.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic        stall;
    logic [31:0] ALU_reg_1, ALU_reg_2, ex_store_data;
    logic [3:0]  ALU_control;
    logic [4:0]  shamt, ex_dest;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .stall(stall), .ALU_reg_1(ALU_reg_1), .ALU_reg_2(ALU_reg_2),
        .ALU_control(ALU_control), .shamt(shamt), .ex_valid(ex_valid),
        .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Contents of the stage as the behaviour rules describe them; an empty
    // stage (bubble or reset) is all zeros.
    typedef struct packed {
        bit          valid;
        bit [4:0]    rs, rt, dest, shamt;
        bit [31:0]   rs_data, rt_data, imm;
        bit [3:0]    aluc;
        bit          alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    } ex_t;

    ex_t m;
    ex_t nxt;
    bit  last_stall;
    int  total;
    int  bad;

    function automatic bit src_hit(logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (FWD) return m.valid && m.mem_read && (m.dest == s);
        return (m.valid && m.reg_write && (m.dest == s))
            || (exmem_reg_write && (exmem_dest == s));
    endfunction

    function automatic bit exp_stall();
        if (!rst_n || flush || !id_valid) return 1'b0;
        return src_hit(id_rs) || src_hit(id_rt);
    endfunction

    function automatic logic [31:0] exp_fwd(logic [4:0] src, logic [31:0] d);
        if (FWD && src != 5'd0) begin
            if (exmem_reg_write && exmem_dest == src) return exmem_result;
            if (memwb_reg_write && memwb_dest == src) return memwb_result;
        end
        return d;
    endfunction

    function automatic ex_t capture(bit stl);
        ex_t n;
        n = '0;
        if (id_valid && !flush && !stl) begin
            n.valid      = 1'b1;
            n.rs         = id_rs;
            n.rt         = id_rt;
            n.dest       = id_reg_dst ? id_rd : id_rt;
            n.shamt      = id_shamt;
            n.rs_data    = id_rs_data;
            n.rt_data    = id_rt_data;
            n.imm        = id_imm;
            n.aluc       = id_alu_control;
            n.alu_src    = id_alu_src;
            n.mem_read   = id_mem_read;
            n.mem_write  = id_mem_write;
            n.reg_write  = id_reg_write;
            n.mem_to_reg = id_mem_to_reg;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string where);
        logic [31:0] st;
        st = exp_fwd(m.rt, m.rt_data);
        check({where, ".alu1"},  ALU_reg_1, exp_fwd(m.rs, m.rs_data));
        check({where, ".alu2"},  ALU_reg_2, m.alu_src ? m.imm : st);
        check({where, ".store"}, ex_store_data, st);
        check({where, ".aluc"},  {28'd0, ALU_control}, {28'd0, m.aluc});
        check({where, ".shamt"}, {27'd0, shamt}, {27'd0, m.shamt});
        check({where, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        check({where, ".dest"},  {27'd0, ex_dest}, {27'd0, m.dest});
        check({where, ".ctrl"},
              {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
              {28'd0, m.mem_read, m.mem_write, m.reg_write, m.mem_to_reg});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                             bit [31:0] rsd, bit [31:0] rtd, bit [31:0] imm,
                             bit [3:0] aluc, bit asrc, bit rdst,
                             bit mr, bit mw, bit rw, bit m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_shamt = rd; id_alu_control = aluc; id_alu_src = asrc; id_reg_dst = rdst;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw; id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(bit ew, bit [4:0] ed, bit [31:0] er,
                           bit mw, bit [4:0] md, bit [31:0] mr);
        exmem_reg_write = ew; exmem_dest = ed; exmem_result = er;
        memwb_reg_write = mw; memwb_dest = md; memwb_result = mr;
    endtask

    task automatic rand_id();
        id_valid       = ($urandom_range(0, 9) != 0);
        id_rs          = 5'($urandom_range(0, 3));
        id_rt          = 5'($urandom_range(0, 3));
        id_rd          = 5'($urandom_range(0, 3));
        id_rs_data     = $urandom;
        id_rt_data     = $urandom;
        id_imm         = $urandom;
        id_shamt       = 5'($urandom_range(0, 31));
        id_alu_control = 4'($urandom_range(0, 15));
        id_alu_src     = 1'($urandom_range(0, 1));
        id_reg_dst     = 1'($urandom_range(0, 1));
        id_mem_read    = ($urandom_range(0, 2) == 0);
        id_mem_write   = ($urandom_range(0, 3) == 0);
        id_reg_write   = 1'($urandom_range(0, 1));
        id_mem_to_reg  = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_fwd();
        set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    endtask

    // Called just after the falling edge with inputs already driven.
    task automatic pre_edge();
        last_stall = exp_stall();
        #1;
        check("stall", {31'd0, stall}, {31'd0, last_stall});
    endtask

    task automatic do_edge();
        nxt = capture(last_stall);
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit hold;
        total = 0;
        bad   = 0;
        m     = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        rand_id();
        rand_fwd();

        // reset with random inputs
        #1;
        check("rst.stall", {31'd0, stall}, 32'd0);
        check_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold.stall", {31'd0, stall}, 32'd0);
        check_outputs("rst_hold");

        // first instruction after release
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1, 1, 2, 3, 32'h11, 32'h22, 32'h4, 4'b0010, 0, 1, 0, 0, 1, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        pre_edge(); do_edge();
        check("first.valid", {31'd0, ex_valid}, 32'd1);
        check("first.alu1", ALU_reg_1, 32'h11);
        check_outputs("first");

        // EX/MEM beats MEM/WB when both match rs
        @(negedge clk);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre_edge(); do_edge();
        check_outputs("idle");
        @(negedge clk);
        set_instr(1, 8, 2, 10, 32'hAAAA, 32'hBBBB, 32'h0, 4'b0110, 0, 1, 0, 0, 1, 0);
        pre_edge(); do_edge();
        set_fwd(1, 8, 32'h10, 1, 8, 32'h20);
        #1;
        check("fwd.prio", ALU_reg_1, FWD ? 32'h10 : 32'hAAAA);
        check_outputs("fwd");
        set_fwd(0, 8, 32'h10, 1, 8, 32'h20);
        #1;
        check("fwd.memwb", ALU_reg_1, FWD ? 32'h20 : 32'hAAAA);
        check_outputs("fwd_wb");

        // load-use: LW r9, then a consumer of r9
        @(negedge clk);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_instr(1, 1, 9, 0, 32'h1, 32'h2, 32'h40, 4'b0010, 1, 0, 1, 0, 1, 1);
        pre_edge(); do_edge();
        check_outputs("lw");
        @(negedge clk);
        set_instr(1, 3, 9, 4, 32'h33, 32'h99, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        pre_edge();
        check("lu.stall", {31'd0, stall}, 32'd1);
        do_edge();
        check("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu.bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        check_outputs("lu_bubble");
        @(negedge clk);
        pre_edge();
        check("lu.release", {31'd0, stall}, 32'd0);
        do_edge();
        check("lu.issue_valid", {31'd0, ex_valid}, 32'd1);
        check_outputs("lu_issue");

        // load-use coinciding with flush
        @(negedge clk);
        set_instr(1, 1, 9, 0, 32'h1, 32'h2, 32'h40, 4'b0010, 1, 0, 1, 0, 1, 1);
        pre_edge(); do_edge();
        @(negedge clk);
        set_instr(1, 9, 2, 4, 32'h5, 32'h6, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        flush = 1'b1;
        pre_edge();
        check("flush.stall", {31'd0, stall}, 32'd0);
        do_edge();
        check("flush.valid", {31'd0, ex_valid}, 32'd0);
        check_outputs("flush");
        flush = 1'b0;

        // register 0 never hazards or forwards
        @(negedge clk);
        set_instr(1, 1, 2, 0, 32'h1, 32'h2, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        pre_edge(); do_edge();
        @(negedge clk);
        set_instr(1, 0, 0, 5, 32'h1234, 32'h5678, 32'h0, 4'b0001, 0, 1, 0, 0, 1, 0);
        set_fwd(1, 0, 32'hFFFF, 1, 0, 32'hEEEE);
        pre_edge();
        check("r0.stall", {31'd0, stall}, 32'd0);
        do_edge();
        check("r0.alu1", ALU_reg_1, 32'h1234);
        check("r0.alu2", ALU_reg_2, 32'h5678);
        check_outputs("r0");

        // ADD r5 then dependent ADD: two stalls without forwarding
        @(negedge clk);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_instr(1, 1, 2, 5, 32'h1, 32'h2, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        pre_edge(); do_edge();
        @(negedge clk);
        set_instr(1, 5, 5, 6, 32'h51, 32'h52, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        pre_edge();
        check("nf.stall1", {31'd0, stall}, FWD ? 32'd0 : 32'd1);
        do_edge();
        check_outputs("nf1");
        @(negedge clk);
        set_fwd(1, 5, 32'h99, 0, 0, 0);
        pre_edge();
        check("nf.stall2", {31'd0, stall}, FWD ? 32'd0 : 32'd1);
        do_edge();
        check_outputs("nf2");
        @(negedge clk);
        set_fwd(0, 0, 0, 1, 5, 32'h99);
        id_rs_data = 32'h99;
        id_rt_data = 32'h99;
        pre_edge();
        check("nf.stall3", {31'd0, stall}, 32'd0);
        do_edge();
        check("nf.alu1", ALU_reg_1, 32'h99);
        check_outputs("nf3");

        // reset asserted while a load-use stall is pending
        @(negedge clk);
        set_fwd(0, 0, 0, 0, 0, 0);
        set_instr(1, 1, 9, 0, 32'h1, 32'h2, 32'h40, 4'b0010, 1, 0, 1, 0, 1, 1);
        pre_edge(); do_edge();
        @(negedge clk);
        set_instr(1, 9, 9, 4, 32'h5, 32'h6, 32'h0, 4'b0010, 0, 1, 0, 0, 1, 0);
        pre_edge();
        check("rst_mid.pre", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        m = '0;
        check("rst_mid.stall", {31'd0, stall}, 32'd0);
        check_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        pre_edge(); do_edge();
        check_outputs("rst_after");

        // random traffic; decode holds its instruction while stalled
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!hold) rand_id();
            flush = ($urandom_range(0, 9) == 0);
            rand_fwd();
            pre_edge();
            hold = last_stall;
            do_edge();
            check_outputs("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
